id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- Pipeline register between the decode stage (control-signal decoder, register file, immediate generator) and the execute stage of the RV64 five-stage core.
- Captures decoded control signals and operands once per cycle.
- Detects load-use hazards and inserts a one-cycle bubble while stalling PC and IF/ID.
- Squashes the captured instruction on a taken-branch flush, and keeps saturating stall and flush event counters for debug.

Parameters:
- DATA_W, 64, operand / PC / immediate width
- REG_AW, 5, register index width
- CNT_W, 16, width of each event counter

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_pc  in  DATA_W  PC of the ID instruction
- id_rs1_data  in  DATA_W  register-file read port 1
- id_rs2_data  in  DATA_W  register-file read port 2
- id_imm  in  DATA_W  sign-extended immediate
- id_rs1  in  REG_AW  source register 1 index
- id_rs2  in  REG_AW  source register 2 index
- id_rd  in  REG_AW  destination register index
- id_funct  in  4  {funct7[5], funct3} for ALU control
- id_Branch, id_MemRead, id_MemToReg, id_MemWrite, id_ALUSrc, id_RegWrite  in  1 each  decoded control signals
- id_ALUOp  in  2  decoded ALU op class
- flush_i  in  1  taken branch resolved downstream; squash ID
- ex_valid  out  1  EX holds a real instruction
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  DATA_W each  registered copies
- ex_rs1, ex_rs2, ex_rd  out  REG_AW each  registered copies
- ex_funct  out  4  registered copy
- ex_Branch, ex_MemRead, ex_MemToReg, ex_MemWrite, ex_ALUSrc, ex_RegWrite  out  1 each  registered controls
- ex_ALUOp  out  2  registered copy
- stall_o  out  1  combinational; holds PC and IF/ID this cycle
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters

Behaviour:
- Reset (rst_n=0, async): every registered output = 0, including ex_valid, all controls, data fields and both counters. stall_o = 0 while in reset.
- Latency: 1 cycle. On each rising edge outside reset, all ex_* data/index/funct fields load the id_* values unconditionally, including during a bubble or flush.
- uses_rs2 = ~id_ALUSrc | id_MemWrite. This covers R-type, beq and sd.
- hazard = id_valid & ex_valid & ex_MemRead & (ex_rd != 0) & ((id_rs1 == ex_rd) | (uses_rs2 & (id_rs2 == ex_rd))).
- stall_o = hazard & ~flush_i. A flush overrides the stall, because the ID instruction is on the wrong path.
- Control capture priority:
  - flush_i = 1 -> ex_valid and all control outputs load 0; flush_cnt increments.
  - else stall_o = 1 -> ex_valid and all control outputs load 0 (bubble); stall_cnt increments.
  - else -> ex_valid <= id_valid; controls <= id_* controls ANDed with id_valid.
- A real instruction is never lost on a stall: upstream holds it, and it is re-presented the next cycle. That cycle sees no hazard, because EX now holds the bubble.
- Load-use on x0 (ex_rd = 0) never stalls.
- Counters: increment by 1 per qualifying edge and saturate at all-ones (no wrap). Flush and stall cannot both count in the same cycle.
- Simultaneous flush and hazard: flush wins; stall_o = 0; only flush_cnt increments.
- Reset asserted mid-stall: outputs clear immediately; stall_o drops with them.

Test Plan:
- Reset: rst_n=0 with random id_* inputs -> all ex_* = 0, ex_valid = 0, stall_o = 0, counters = 0. Release -> first edge loads ID.
- Pass-through: add x3,x1,x2 (R-type, ALUOp=10, RegWrite=1) -> next cycle ex_rd = 3, ex_ALUOp = 10, ex_RegWrite = 1, ex_valid = 1, stall_o = 0.
- Load-use: ld x5,0(x1), then add x6,x5,x7 -> stall_o = 1 for exactly 1 cycle. EX gets a bubble (ex_valid = 0, ex_RegWrite = 0). The add enters EX one cycle later. stall_cnt = 1.
- sd rs2 dependency: ld x5, then sd x5,8(x2) -> stall (via uses_rs2). ld x5 then addi x9,x8,1 with id_rs2 field = 5 -> no stall. ld x0 then add x6,x0,x0 -> no stall.
- Flush + hazard in the same cycle (ld x5 in EX, add x6,x5,x7 in ID, flush_i = 1) -> stall_o = 0, ex_valid = 0, all controls 0, flush_cnt +1, stall_cnt unchanged.
- Saturation: force 2^CNT_W + 3 stall events -> stall_cnt = all-ones and holds.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush squash and saturating debug counters.
// Latency 1 cycle; stall_o is combinational and holds PC and IF/ID while EX takes a bubble.
module id_ex_stage #(
  parameter int DATA_W = 64,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [DATA_W-1:0] id_rs1_data,
  input  logic [DATA_W-1:0] id_rs2_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [3:0]        id_funct,
  input  logic              id_Branch,
  input  logic              id_MemRead,
  input  logic              id_MemToReg,
  input  logic              id_MemWrite,
  input  logic              id_ALUSrc,
  input  logic              id_RegWrite,
  input  logic [1:0]        id_ALUOp,
  input  logic              flush_i,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] ex_rs1_data,
  output logic [DATA_W-1:0] ex_rs2_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic [3:0]        ex_funct,
  output logic              ex_Branch,
  output logic              ex_MemRead,
  output logic              ex_MemToReg,
  output logic              ex_MemWrite,
  output logic              ex_ALUSrc,
  output logic              ex_RegWrite,
  output logic [1:0]        ex_ALUOp,
  output logic              stall_o,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // Control bundle order: {Branch, MemRead, MemToReg, MemWrite, ALUSrc, RegWrite, ALUOp[1:0]}
  logic [7:0]        id_ctrl;
  logic [7:0]        ctrl_d, ctrl_q;
  logic              valid_d, valid_q;
  logic [CNT_W-1:0]  stall_cnt_d, stall_cnt_q;
  logic [CNT_W-1:0]  flush_cnt_d, flush_cnt_q;
  logic [DATA_W-1:0] pc_q, rs1_data_q, rs2_data_q, imm_q;
  logic [REG_AW-1:0] rs1_q, rs2_q, rd_q;
  logic [3:0]        funct_q;
  logic              uses_rs2;
  logic              hazard;

  assign id_ctrl = {id_Branch, id_MemRead, id_MemToReg, id_MemWrite,
                    id_ALUSrc, id_RegWrite, id_ALUOp};

  // R-type, branches and stores read rs2; I-type ALU ops and loads do not.
  assign uses_rs2 = ~id_ALUSrc | id_MemWrite;
  assign hazard   = id_valid & valid_q & ctrl_q[6] & (rd_q != '0) &
                    ((id_rs1 == rd_q) | (uses_rs2 & (id_rs2 == rd_q)));
  assign stall_o  = hazard & ~flush_i;

  always_comb begin
    valid_d     = id_valid;
    ctrl_d      = id_ctrl & {8{id_valid}};
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (flush_i) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
    end else if (stall_o) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      ctrl_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      pc_q        <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      funct_q     <= '0;
    end else begin
      valid_q     <= valid_d;
      ctrl_q      <= ctrl_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      pc_q        <= id_pc;
      rs1_data_q  <= id_rs1_data;
      rs2_data_q  <= id_rs2_data;
      imm_q       <= id_imm;
      rs1_q       <= id_rs1;
      rs2_q       <= id_rs2;
      rd_q        <= id_rd;
      funct_q     <= id_funct;
    end
  end

  assign ex_valid    = valid_q;
  assign ex_pc       = pc_q;
  assign ex_rs1_data = rs1_data_q;
  assign ex_rs2_data = rs2_data_q;
  assign ex_imm      = imm_q;
  assign ex_rs1      = rs1_q;
  assign ex_rs2      = rs2_q;
  assign ex_rd       = rd_q;
  assign ex_funct    = funct_q;
  assign {ex_Branch, ex_MemRead, ex_MemToReg, ex_MemWrite,
          ex_ALUSrc, ex_RegWrite, ex_ALUOp} = ctrl_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule
